// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and parity method constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // dataXor is the XOR of all data bits; returns 1 when the received parity bit is wrong.
  function automatic logic parityErr(input logic dataXor, input logic parBit, input logic method);
    case (method)
      PARITY_EVEN: return dataXor ^ parBit;
      PARITY_ODD:  return ~(dataXor ^ parBit);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy level and sticky overflow.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     empty,
  output logic                     full,
  output logic                     over,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     written
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doRd;
  logic             doWr;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign doRd  = rdEn && !empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO still succeeds.
  assign doWr  = wrEn && (!full || doRd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      over    <= 1'b0;
      rdData  <= '0;
      written <= 1'b0;
    end else if (clr) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      over    <= 1'b0;
      written <= 1'b0;
    end else begin
      written <= doWr;
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) begin
        rdPtr  <= rdPtr + 1'b1;
        rdData <= mem[rdPtr];
      end
      if (wrEn && !doWr) over <= 1'b1;
      if (doWr && !doRd) level <= level + 1'b1;
      else if (doRd && !doWr) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doWr && !clr && !rst) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with receive FIFO and sticky error flags.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote around the mid sample.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        p_Enable_i,
  input  logic                        AcqSig_i,
  input  logic [3:0]                  AcqNumPerBit_i,
  input  logic                        p_ParityEnable_i,
  input  logic                        ParityMethod_i,
  input  logic                        p_BigEnd_i,
  input  logic                        Rx_i,
  input  logic                        n_Rd_i,
  input  logic                        n_Clr_i,
  output logic [DATA_W-1:0]           Data_o,
  output logic                        p_Empty_o,
  output logic                        p_Full_o,
  output logic                        p_Over_o,
  output logic [$clog2(FIFO_DEPTH):0] Level_o,
  output logic                        p_ParityErr_o,
  output logic                        p_FrameErr_o,
  output logic                        p_ByteRcvd_o,
  output rxState_e                    dbgState
);

  logic              rxMeta, rxSync, rxPrev;
  rxState_e          state;
  logic [3:0]        acqCnt, acqNum, bitCnt;
  logic [3:0]        midCnt, lastCnt, decCnt;
  logic              bitVal;
  logic [DATA_W-1:0] shreg, frameData;
  logic              parEn, parMethod, bigEnd, parErrPend, frameWr;

  assign dbgState = state;
  assign midCnt   = acqNum >> 1;
  assign lastCnt  = acqNum - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= Rx_i;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote0, vote1;
  always_ff @(posedge clk) begin
    if (rst) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
    end else if (AcqSig_i) begin
      if (acqCnt == midCnt - 4'd1) vote0 <= rxSync;
      if (acqCnt == midCnt) vote1 <= rxSync;
    end
  end
  // Decision is taken on the mid+1 strobe, when all three samples are available.
  assign decCnt = midCnt + 4'd1;
  assign bitVal = (vote0 & vote1) | (vote0 & rxSync) | (vote1 & rxSync);
`else
  assign decCnt = midCnt;
  assign bitVal = rxSync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acqCnt        <= '0;
      acqNum        <= '0;
      bitCnt        <= '0;
      shreg         <= '0;
      parEn         <= 1'b0;
      parMethod     <= 1'b0;
      bigEnd        <= 1'b0;
      parErrPend    <= 1'b0;
      frameWr       <= 1'b0;
      frameData     <= '0;
      p_ParityErr_o <= 1'b0;
      p_FrameErr_o  <= 1'b0;
    end else begin
      frameWr <= 1'b0;
      if (!n_Clr_i) begin
        p_ParityErr_o <= 1'b0;
        p_FrameErr_o  <= 1'b0;
      end
      if (state != IDLE && !p_Enable_i) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (p_Enable_i && rxPrev && !rxSync) begin
          state      <= START;
          acqCnt     <= '0;
          bitCnt     <= '0;
          acqNum     <= AcqNumPerBit_i;
          parEn      <= p_ParityEnable_i;
          parMethod  <= ParityMethod_i;
          bigEnd     <= p_BigEnd_i;
          parErrPend <= 1'b0;
        end
      end else if (AcqSig_i) begin
        acqCnt <= (acqCnt == lastCnt) ? '0 : acqCnt + 4'd1;
        if (acqCnt == decCnt) begin
          case (state)
            START:  if (bitVal) state <= IDLE;
            DATA:   shreg <= bigEnd ? {shreg[DATA_W-2:0], bitVal} : {bitVal, shreg[DATA_W-1:1]};
            PARITY: parErrPend <= parityErr(^shreg, bitVal, parMethod);
            STOP: begin
              // Flags commit only here so an aborted frame leaves them untouched.
              frameWr   <= 1'b1;
              frameData <= shreg;
              state     <= IDLE;
              if (n_Clr_i) begin
                if (parErrPend) p_ParityErr_o <= 1'b1;
                if (!bitVal) p_FrameErr_o <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (acqCnt == lastCnt) begin
          case (state)
            START:  state <= DATA;
            DATA: begin
              if (bitCnt == 4'(DATA_W - 1)) begin
                bitCnt <= '0;
                state  <= parEn ? PARITY : STOP;
              end else begin
                bitCnt <= bitCnt + 4'd1;
              end
            end
            PARITY: state <= STOP;
            default: ;
          endcase
        end
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!n_Clr_i),
    .wrEn    (frameWr),
    .wrData  (frameData),
    .rdEn    (!n_Rd_i),
    .rdData  (Data_o),
    .empty   (p_Empty_o),
    .full    (p_Full_o),
    .over    (p_Over_o),
    .level   (Level_o),
    .written (p_ByteRcvd_o)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized bench for uart_rx_param against a frame-level reference model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic           clk, rst;
  logic           p_Enable_i, AcqSig_i, p_ParityEnable_i, ParityMethod_i, p_BigEnd_i;
  logic [3:0]     AcqNumPerBit_i;
  logic           Rx_i, n_Rd_i, n_Clr_i;
  logic [DW-1:0]  Data_o;
  logic           p_Empty_o, p_Full_o, p_Over_o, p_ParityErr_o, p_FrameErr_o, p_ByteRcvd_o;
  logic [2:0]     Level_o;
  rxState_e       dbgState;

  int checks = 0;
  int errors = 0;
  int rcvdCnt = 0;
  int expWrites = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] lastData = '0;
  logic expPar = 1'b0, expFrm = 1'b0, expOver = 1'b0;

  uart_rx_param #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .p_Enable_i(p_Enable_i), .AcqSig_i(AcqSig_i),
    .AcqNumPerBit_i(AcqNumPerBit_i), .p_ParityEnable_i(p_ParityEnable_i),
    .ParityMethod_i(ParityMethod_i), .p_BigEnd_i(p_BigEnd_i), .Rx_i(Rx_i),
    .n_Rd_i(n_Rd_i), .n_Clr_i(n_Clr_i), .Data_o(Data_o), .p_Empty_o(p_Empty_o),
    .p_Full_o(p_Full_o), .p_Over_o(p_Over_o), .Level_o(Level_o),
    .p_ParityErr_o(p_ParityErr_o), .p_FrameErr_o(p_FrameErr_o),
    .p_ByteRcvd_o(p_ByteRcvd_o), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && p_ByteRcvd_o) rcvdCnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One acquisition period: line value held for four clocks, strobe in the last one.
  task automatic drive_period(input logic v);
    Rx_i = v;
    AcqSig_i = 1'b0;
    tick(); tick(); tick();
    AcqSig_i = 1'b1;
    tick();
    AcqSig_i = 1'b0;
  endtask

  task automatic do_read(input string tag);
    n_Rd_i = 1'b0;
    tick();
    n_Rd_i = 1'b1;
    if (exp_q.size() > 0) lastData = exp_q.pop_front();
    check(tag, 32'(Data_o), 32'(lastData));
  endtask

  task automatic do_clear();
    n_Clr_i = 1'b0;
    tick();
    n_Clr_i = 1'b1;
    exp_q.delete();
    expPar = 1'b0;
    expFrm = 1'b0;
    expOver = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 32'(Level_o), 32'(exp_q.size()));
    check({tag, "_empty"}, 32'(p_Empty_o), 32'(exp_q.size() == 0));
    check({tag, "_full"}, 32'(p_Full_o), 32'(exp_q.size() == DEPTH));
    check({tag, "_over"}, 32'(p_Over_o), 32'(expOver));
    check({tag, "_parerr"}, 32'(p_ParityErr_o), 32'(expPar));
    check({tag, "_frmerr"}, 32'(p_FrameErr_o), 32'(expFrm));
    check({tag, "_rcvd"}, 32'(rcvdCnt), 32'(expWrites));
  endtask

  // Transmit a frame strobe by strobe, then decode the line with the sampling rules
  // and update the expected FIFO contents and flags.
  task automatic send_frame(input logic [7:0] d, input logic be, input logic pe, input logic pm,
                            input logic badPar, input logic stopVal, input logic [3:0] num,
                            input int flipIdx, input int abortAt, input bit scramble);
    logic bits[$];
    logic line[$];
    logic dec[$];
    logic [7:0] got;
    logic v;
    int mid, p, nb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(be ? d[7-i] : d[i]);
    if (pe) bits.push_back((^d) ^ pm ^ badPar);
    bits.push_back(stopVal);
    nb = bits.size();
    for (int b = 0; b < nb; b++)
      for (int s = 0; s < int'(num); s++) line.push_back(bits[b]);
    if (flipIdx >= 0) line[flipIdx] = ~line[flipIdx];
    p_BigEnd_i = be;
    p_ParityEnable_i = pe;
    ParityMethod_i = pm;
    AcqNumPerBit_i = num;
    for (int k = 0; k < line.size(); k++) begin
      if (k == abortAt) begin
        p_Enable_i = 1'b0;
        tick();
        check("abort_state", 32'(dbgState), 32'(IDLE));
      end
      drive_period(line[k]);
      if (k == 0 && scramble) begin
        p_BigEnd_i = 1'($urandom_range(0, 1));
        p_ParityEnable_i = 1'($urandom_range(0, 1));
        ParityMethod_i = 1'($urandom_range(0, 1));
        AcqNumPerBit_i = 4'($urandom_range(4, 15));
      end
    end
    drive_period(1'b1);
    drive_period(1'b1);
    p_Enable_i = 1'b1;
    if (abortAt >= 0) return;
    mid = int'(num) / 2;
    for (int b = 0; b < nb; b++) begin
      p = b * int'(num) + mid;
`ifdef UART_RX_MAJORITY_VOTE_EN
      v = (line[p-1] & line[p]) | (line[p-1] & line[p+1]) | (line[p] & line[p+1]);
`else
      v = line[p];
`endif
      dec.push_back(v);
    end
    if (dec[0]) return;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      if (be) got[7-i] = dec[1+i];
      else got[i] = dec[1+i];
    end
    if (pe && (((^got) ^ dec[9]) != pm)) expPar = 1'b1;
    if (!dec[nb-1]) expFrm = 1'b1;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(got);
      expWrites++;
    end else begin
      expOver = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    p_Enable_i = 1'b1;
    AcqSig_i = 1'b0;
    AcqNumPerBit_i = 4'd8;
    p_ParityEnable_i = 1'b0;
    ParityMethod_i = 1'b0;
    p_BigEnd_i = 1'b0;
    Rx_i = 1'b1;
    n_Rd_i = 1'b1;
    n_Clr_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_data", 32'(Data_o), 32'h0);
    check("rst_state", 32'(dbgState), 32'(IDLE));
    check("rst_byte", 32'(p_ByteRcvd_o), 32'h0);
    check_status("rst");
    drive_period(1'b1);

    // 0xA5, LSB first, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, -1, -1, 1'b0);
    check_status("a5");
    check("a5_noflags", 32'({p_ParityErr_o, p_FrameErr_o, p_Over_o}), 32'h0);
    do_read("a5_read");
    check("a5_const", 32'(Data_o), 32'hA5);

    // 0x3C, MSB first, odd parity, wrong parity bit
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8, -1, -1, 1'b0);
    check("3c_parerr", 32'(p_ParityErr_o), 32'h1);
    check_status("3c");
    do_read("3c_read");
    check("3c_const", 32'(Data_o), 32'h3C);
    do_clear();
    check_status("clr1");

    // stop bit held low
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, -1, -1, 1'b0);
    check("stop0_frmerr", 32'(p_FrameErr_o), 32'h1);
    check("stop0_level", 32'(Level_o), 32'h1);
    check_status("stop0");
    do_read("stop0_read");
    do_clear();

    // two-strobe low glitch on an idle line
    drive_period(1'b0);
    drive_period(1'b0);
    repeat (10) drive_period(1'b1);
    check("glitch_state", 32'(dbgState), 32'(IDLE));
    check_status("glitch");

    // single-strobe inversion at the mid sample of data bit 3 of 0x00
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 4 * 8 + 4, -1, 1'b0);
    check_status("flip");
    do_read("flip_read");
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("flip_const", 32'(Data_o), 32'h00);
`else
    check("flip_const", 32'(Data_o), 32'h08);
`endif

    // five frames without reads into a four-entry FIFO
    for (int f = 0; f < 5; f++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 4'($urandom_range(4, 15)), -1, -1, 1'b0);
    end
    check("ovf_level", 32'(Level_o), 32'd4);
    check("ovf_full", 32'(p_Full_o), 32'h1);
    check("ovf_over", 32'(p_Over_o), 32'h1);
    check_status("ovf");
    for (int f = 0; f < 4; f++) do_read("ovf_read");
    check_status("ovf_drained");
    do_clear();

    // disable mid-frame: no write, no flag change
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, -1, 40, 1'b0);
    check_status("abort");

    // read while empty keeps Data_o
    do_read("empty_read");
    check_status("empty");

    // randomized frames with configuration scrambled after start detection
    for (int f = 0; f < 12; f++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) != 0), 4'($urandom_range(4, 15)), -1, -1, 1'b1);
      check_status("rnd");
      if ($urandom_range(0, 1) == 1) do_read("rnd_read");
      if ($urandom_range(0, 5) == 0) begin
        do_clear();
        check_status("rnd_clr");
      end
    end
    while (exp_q.size() > 0) do_read("final_read");
    check_status("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
